// File: rtl/tlb_refill_walker_if.sv
// Signal bundle around the TLB refill walker: miss request from the MMU lookup
// path, read-only port toward the memory arbiter, TLB write port and status.
interface tlb_refill_walker_if;
    logic        missValid;
    logic [31:0] missAddress;
    logic [31:0] pdBase;
    logic        abort;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memData;
    logic        WriteTLB;
    logic [31:0] index;
    logic [31:0] entryHi;
    logic [31:0] entryLo0;
    logic [31:0] entryLo1;
    logic        busy;
    logic        done;
    logic        fault;

    // Walker side
    modport master (
        input  missValid, missAddress, pdBase, abort, memAck, memData,
        output memReq, memAddr, WriteTLB, index, entryHi, entryLo0, entryLo1,
               busy, done, fault
    );

    // Environment side: MMU, memory arbiter, TLB and exception logic
    modport slave (
        output missValid, missAddress, pdBase, abort, memAck, memData,
        input  memReq, memAddr, WriteTLB, index, entryHi, entryLo0, entryLo1,
               busy, done, fault
    );
endinterface

// File: rtl/tlb_refill_walker.sv
// Two-level page-table walker that refills a 16-entry TLB with an even/odd
// PTE pair. Reads PDE, then both PTEs, then writes the round-robin victim slot.
module tlb_refill_walker (
    input  logic                clock,
    input  logic                reset,
    tlb_refill_walker_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PDE,
        S_PTE0,
        S_PTE1,
        S_WRITE,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  victim_q, victim_d;
    logic [3:0]  index_q, index_d;
    logic [31:0] entry_hi_q, entry_hi_d;
    logic [31:0] entry_lo0_q, entry_lo0_d;
    logic [31:0] entry_lo1_q, entry_lo1_d;

    // Walk context: VPN2 of the faulting address, directory base, table frame
    // and the even PTE held until the pair is complete.
    logic [18:0] vpn2_q, vpn2_d;
    logic [31:0] pd_base_q, pd_base_d;
    logic [19:0] pt_frame_q, pt_frame_d;
    logic [31:0] pte0_q, pte0_d;
    logic        walking;

    // Next state, walk context capture and TLB entry assembly
    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        index_d     = index_q;
        entry_hi_d  = entry_hi_q;
        entry_lo0_d = entry_lo0_q;
        entry_lo1_d = entry_lo1_q;
        vpn2_d      = vpn2_q;
        pd_base_d   = pd_base_q;
        pt_frame_d  = pt_frame_q;
        pte0_d      = pte0_q;
        case (state_q)
            S_IDLE: begin
                // A flush in the same cycle as the miss wins: nothing starts.
                if (bus.missValid && !bus.abort) begin
                    vpn2_d    = bus.missAddress[31:13];
                    pd_base_d = bus.pdBase;
                    state_d   = (bus.missAddress[31:30] == 2'b10) ? S_FAULT : S_PDE;
                end
            end
            S_PDE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.memAck) begin
                    if (!bus.memData[0]) begin
                        state_d = S_FAULT;
                    end else begin
                        pt_frame_d = bus.memData[31:12];
                        state_d    = S_PTE0;
                    end
                end
            end
            S_PTE0: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.memAck) begin
                    pte0_d  = bus.memData;
                    state_d = S_PTE1;
                end
            end
            S_PTE1: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.memAck) begin
                    // Visible entry registers change only when a write is certain,
                    // so aborted walks never disturb the last written entry.
                    entry_lo0_d = pte0_q;
                    entry_lo1_d = bus.memData;
                    entry_hi_d  = {vpn2_q, 13'h0};
                    index_d     = victim_q;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                victim_d = victim_q + 4'd1;
                state_d  = S_IDLE;
            end
            S_FAULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and the registered TLB write-port outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            victim_q    <= 4'd0;
            index_q     <= 4'd0;
            entry_hi_q  <= 32'h0;
            entry_lo0_q <= 32'h0;
            entry_lo1_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            victim_q    <= victim_d;
            index_q     <= index_d;
            entry_hi_q  <= entry_hi_d;
            entry_lo0_q <= entry_lo0_d;
            entry_lo1_q <= entry_lo1_d;
        end
    end

    // Walk context is only consumed inside a walk, so it carries no reset
    always_ff @(posedge clock) begin
        vpn2_q     <= vpn2_d;
        pd_base_q  <= pd_base_d;
        pt_frame_q <= pt_frame_d;
        pte0_q     <= pte0_d;
    end

    // Bus and status outputs decoded from the registered state
    always_comb begin
        walking      = (state_q == S_PDE) || (state_q == S_PTE0) || (state_q == S_PTE1);
        // Request is withdrawn in the flush cycle itself; any ack then is moot.
        bus.memReq   = walking && !bus.abort;
        bus.memAddr  = 32'h0;
        case (state_q)
            S_PDE:   bus.memAddr = pd_base_q + {20'h0, vpn2_q[18:9], 2'b00};
            S_PTE0:  bus.memAddr = {pt_frame_q, vpn2_q[8:0], 3'b000};
            S_PTE1:  bus.memAddr = {pt_frame_q, vpn2_q[8:0], 3'b100};
            default: bus.memAddr = 32'h0;
        endcase
        bus.WriteTLB = (state_q == S_WRITE);
        bus.done     = (state_q == S_WRITE);
        bus.fault    = (state_q == S_FAULT);
        bus.busy     = (state_q != S_IDLE);
        bus.index    = {28'h0, index_q};
        bus.entryHi  = entry_hi_q;
        bus.entryLo0 = entry_lo0_q;
        bus.entryLo1 = entry_lo1_q;
    end
endmodule

// File: tb/tb_tlb_refill_walker.sv
// Bench for tlb_refill_walker: walk-level expectations derived from the page
// table contents, checked against the DUT outputs every cycle.
module tb_tlb_refill_walker;
    logic clock = 1'b0;
    logic reset;

    tlb_refill_walker_if bus ();

    tlb_refill_walker dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Physical memory image and responder wait setting
    logic [31:0] mem [logic [31:0]];
    int mem_waits = 0;
    int wcnt      = 0;

    // Expected walk: accepted in cycle w_start, ends (write/fault/cut) in w_end
    int          w_start   = 0;
    int          w_end     = 0;
    int          w_kind    = 0;   // 0 none, 1 write, 2 fault
    int          w_waits   = 0;
    bit          w_cut_rst = 1'b0;
    logic [31:0] w_addr [3];
    logic [31:0] w_hi, w_lo0, w_lo1;
    int          clr_at    = -1;

    // Model of the TLB write-port registers
    logic [3:0]  victim_m = 4'd0;
    logic [31:0] last_idx = 32'h0, last_hi = 32'h0, last_lo0 = 32'h0, last_lo1 = 32'h0;

    // What the DUT was seen doing
    int          wr_count = 0, flt_count = 0, wr_seen_cyc = 0, flt_seen_cyc = 0;
    logic [31:0] seen_idx = 32'h0, seen_hi = 32'h0, seen_lo0 = 32'h0, seen_lo1 = 32'h0;
    int          last_start = 0;

    bit in_walk, e_req, e_wr, e_flt;
    int rd_slot;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Memory arbiter: acknowledge after mem_waits idle cycles of a request
    always @(negedge clock) begin
        if (bus.memReq === 1'b1) begin
            if (wcnt >= mem_waits) begin
                bus.memAck  = 1'b1;
                bus.memData = rd(bus.memAddr);
                wcnt        = 0;
            end else begin
                bus.memAck  = 1'b0;
                bus.memData = $urandom();
                wcnt++;
            end
        end else begin
            bus.memAck  = 1'b0;
            bus.memData = $urandom();
            wcnt        = 0;
        end
    end

    // Per-cycle comparison against the walk-level model
    always @(negedge clock) begin
        if (cyc >= 1) begin
            if (cyc == clr_at) begin
                victim_m = 4'd0;
                last_idx = 32'h0; last_hi = 32'h0; last_lo0 = 32'h0; last_lo1 = 32'h0;
            end
            in_walk = (cyc > w_start) && (cyc <= w_end);
            e_req   = (cyc > w_start) && (w_cut_rst ? (cyc <= w_end) : (cyc < w_end));
            e_wr    = (w_kind == 1) && (cyc == w_end);
            e_flt   = (w_kind == 2) && (cyc == w_end);
            if (e_wr) begin
                last_idx = {28'h0, victim_m};
                last_hi  = w_hi;
                last_lo0 = w_lo0;
                last_lo1 = w_lo1;
                victim_m = victim_m + 4'd1;
            end
            chk("busy", {31'h0, bus.busy}, {31'h0, in_walk});
            chk("memReq", {31'h0, bus.memReq}, {31'h0, e_req});
            if (e_req) begin
                rd_slot = (cyc - w_start - 1) / (w_waits + 1);
                chk("memAddr", bus.memAddr, w_addr[rd_slot]);
            end
            chk("WriteTLB", {31'h0, bus.WriteTLB}, {31'h0, e_wr});
            chk("done", {31'h0, bus.done}, {31'h0, e_wr});
            chk("fault", {31'h0, bus.fault}, {31'h0, e_flt});
            chk("index", bus.index, last_idx);
            chk("entryHi", bus.entryHi, last_hi);
            chk("entryLo0", bus.entryLo0, last_lo0);
            chk("entryLo1", bus.entryLo1, last_lo1);
            if (bus.WriteTLB === 1'b1) begin
                wr_count++;
                wr_seen_cyc = cyc;
                seen_idx = bus.index; seen_hi = bus.entryHi;
                seen_lo0 = bus.entryLo0; seen_lo1 = bus.entryLo1;
            end
            if (bus.fault === 1'b1) begin
                flt_count++;
                flt_seen_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One refill request; abort_off/rst_off are cycle offsets from acceptance
    task automatic refill(input logic [31:0] va, input logic [31:0] pdb, input int wts,
                          input int abort_off, input bit extra_mv, input int rst_off);
        logic [31:0] pde;
        int          nreads;
        bit          kseg;
        kseg       = (va[31:30] == 2'b10);
        w_addr[0]  = pdb + {20'h0, va[31:22], 2'b00};
        pde        = rd(w_addr[0]);
        w_addr[1]  = {pde[31:12], va[21:13], 3'b000};
        w_addr[2]  = {pde[31:12], va[21:13], 3'b100};
        nreads     = kseg ? 0 : (pde[0] ? 3 : 1);
        w_kind     = (kseg || !pde[0]) ? 2 : 1;
        w_hi       = {va[31:13], 13'h0};
        w_lo0      = rd(w_addr[1]);
        w_lo1      = rd(w_addr[2]);
        w_waits    = wts;
        mem_waits  = wts;
        w_cut_rst  = 1'b0;
        w_start    = cyc;
        last_start = cyc;
        w_end      = cyc + 1 + nreads * (wts + 1);
        bus.missValid   = 1'b1;
        bus.missAddress = va;
        bus.pdBase      = pdb;
        step();
        bus.missValid   = 1'b0;
        bus.missAddress = $urandom();
        bus.pdBase      = $urandom();
        while (cyc <= w_end) begin
            if (abort_off > 0 && cyc == w_start + abort_off) begin
                bus.abort = 1'b1;
                if (cyc < w_end) begin
                    w_end  = cyc;
                    w_kind = 0;
                end
            end
            if (rst_off > 0 && cyc == w_start + rst_off) begin
                reset     = 1'b1;
                w_end     = cyc;
                w_kind    = 0;
                w_cut_rst = 1'b1;
                clr_at    = cyc + 1;
            end
            if (extra_mv && cyc == w_start + 1) begin
                bus.missValid   = 1'b1;
                bus.missAddress = 32'h0123_4000;
            end
            step();
            bus.abort     = 1'b0;
            bus.missValid = 1'b0;
            reset         = 1'b0;
        end
    endtask

    logic [31:0] r_va, r_pdb, r_pde, r_a1;
    int          r_wts, r_ab, wc0, fc0;
    bit          r_mv;

    initial begin
        reset           = 1'b1;
        bus.missValid   = 1'b0;
        bus.missAddress = 32'h0;
        bus.pdBase      = 32'h0;
        bus.abort       = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_memAddr", bus.memAddr, 32'h0);
        chk("rst_index", bus.index, 32'h0);

        // Basic refill, zero-wait memory
        mem[32'h0010_0004] = 32'h0020_0001;
        mem[32'h0020_0008] = 32'h0000_1046;
        mem[32'h0020_000C] = 32'h0000_1082;
        wc0 = wr_count;
        refill(32'h0040_2000, 32'h0010_0000, 0, 0, 1'b0, 0);
        chk("basic_latency", 32'(wr_seen_cyc - last_start), 32'd4);
        chk("basic_writes", 32'(wr_count - wc0), 32'd1);
        chk("basic_index", seen_idx, 32'h0);
        chk("basic_entryHi", seen_hi, 32'h0040_2000);
        chk("basic_entryLo0", seen_lo0, 32'h0000_1046);
        chk("basic_entryLo1", seen_lo1, 32'h0000_1082);

        // Same walk with three wait cycles per read
        refill(32'h0040_2000, 32'h0010_0000, 3, 0, 1'b0, 0);
        chk("wait_latency", 32'(wr_seen_cyc - last_start), 32'd13);
        chk("wait_index", seen_idx, 32'd1);

        // Round-robin victim through the wrap
        for (int k = 0; k < 16; k++) begin
            r_va  = {2'b00, 30'($urandom())};
            r_pdb = $urandom() & 32'h0FFF_FFFC;
            mem[r_pdb + {20'h0, r_va[31:22], 2'b00}] = {20'($urandom()), 11'h0, 1'b1};
            r_pde = rd(r_pdb + {20'h0, r_va[31:22], 2'b00});
            mem[{r_pde[31:12], r_va[21:13], 3'b000}] = $urandom();
            mem[{r_pde[31:12], r_va[21:13], 3'b100}] = $urandom();
            refill(r_va, r_pdb, $urandom_range(0, 2), 0, 1'b0, 0);
            chk("rr_index", seen_idx, 32'((k + 2) % 16));
        end

        // Invalid PDE: one read, one fault, no write
        mem[32'h0010_0004] = 32'h0020_0000;
        wc0 = wr_count; fc0 = flt_count;
        refill(32'h0040_2000, 32'h0010_0000, 0, 0, 1'b0, 0);
        chk("pde_faults", 32'(flt_count - fc0), 32'd1);
        chk("pde_writes", 32'(wr_count - wc0), 32'd0);
        chk("pde_latency", 32'(flt_seen_cyc - last_start), 32'd2);

        // Kseg address: fault at N+1, no memory access
        fc0 = flt_count;
        refill(32'h8000_1000, 32'h0010_0000, 0, 0, 1'b0, 0);
        chk("kseg_latency", 32'(flt_seen_cyc - last_start), 32'd1);
        chk("kseg_faults", 32'(flt_count - fc0), 32'd1);

        // Faults left the victim alone
        mem[32'h0010_0004] = 32'h0020_0001;
        refill(32'h0040_2000, 32'h0010_0000, 1, 0, 1'b0, 0);
        chk("post_fault_index", seen_idx, 32'd2);

        // Reset during PTE1
        wc0 = wr_count;
        refill(32'h0040_2000, 32'h0010_0000, 0, 0, 1'b0, 3);
        chk("rst_walk_writes", 32'(wr_count - wc0), 32'd0);
        chk("rst_walk_index", bus.index, 32'h0);
        chk("rst_walk_entryLo1", bus.entryLo1, 32'h0);

        // Abort while waiting in PTE0, then a clean refill into victim 0
        wc0 = wr_count;
        refill(32'h0040_2000, 32'h0010_0000, 3, 6, 1'b0, 0);
        chk("abort_writes", 32'(wr_count - wc0), 32'd0);
        chk("abort_busy", {31'h0, bus.busy}, 32'h0);
        refill(32'h0040_2000, 32'h0010_0000, 0, 0, 1'b0, 0);
        chk("after_abort_index", seen_idx, 32'h0);
        chk("after_abort_entryLo0", seen_lo0, 32'h0000_1046);

        // missValid while busy is ignored
        wc0 = wr_count;
        refill(32'h0040_2000, 32'h0010_0000, 2, 0, 1'b1, 0);
        chk("busy_mv_writes", 32'(wr_count - wc0), 32'd1);

        // abort together with missValid in IDLE
        bus.missValid   = 1'b1;
        bus.abort       = 1'b1;
        bus.missAddress = 32'h0040_2000;
        bus.pdBase      = 32'h0010_0000;
        step();
        bus.missValid = 1'b0;
        bus.abort     = 1'b0;
        chk("idle_abort_busy", {31'h0, bus.busy}, 32'h0);
        step();

        // Randomized walks: kseg, invalid PDEs, waits, aborts, busy requests
        for (int k = 0; k < 30; k++) begin
            r_va = $urandom();
            if ($urandom_range(0, 7) == 0) r_va[31:30] = 2'b10;
            else if (r_va[31:30] == 2'b10) r_va[30] = 1'b1;
            r_pdb = $urandom() & 32'hFFFF_FFFC;
            r_pde = $urandom();
            r_pde[0] = ($urandom_range(0, 3) != 0);
            mem[r_pdb + {20'h0, r_va[31:22], 2'b00}] = r_pde;
            r_a1 = {r_pde[31:12], r_va[21:13], 3'b000};
            mem[r_a1]           = $urandom();
            mem[r_a1 | 32'h4]   = $urandom();
            r_wts = $urandom_range(0, 3);
            r_ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 1 + 3 * (r_wts + 1)) : 0;
            r_mv  = ($urandom_range(0, 1) == 1);
            refill(r_va, r_pdb, r_wts, r_ab, r_mv, 0);
        end
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
        $fatal(1, "watchdog");
    end
endmodule
